// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_cycle #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [4:0]        RD_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic              FlushE,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ALU_ResultM
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] write_data_e;
  logic [DATA_W-1:0] alu_result;
  logic              zero_e;
  logic              slt_e;

  // Forwarding muxes; 2'b10 takes the previous instruction's registered ALU result.
  always_comb begin
    src_a = RD1_E;
    unique case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase

    write_data_e = RD2_E;
    unique case (ForwardB_E)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALU_ResultM;
      default: write_data_e = RD2_E;
    endcase

    src_b = ALUSrcE ? Imm_Ext_E : write_data_e;
  end

  // ALU; unused opcodes produce zero, arithmetic wraps.
  always_comb begin
    slt_e      = $signed(src_a) < $signed(src_b);
    alu_result = '0;
    unique case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(DATA_W-1){1'b0}}, slt_e};
      default: alu_result = '0;
    endcase
  end

  // Branch resolution back to fetch; a squashed instruction never redirects.
  always_comb begin
    zero_e    = (alu_result == '0);
    PCSrcE    = BranchE & zero_e & ~FlushE;
    PCTargetE = PCE + Imm_Ext_E;
  end

  // EX/MEM register: reset beats flush, flush only has to kill the side-effecting controls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE & ~FlushE;
      MemWriteM   <= MemWriteE & ~FlushE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data_e;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vector table, reset sequences and a randomized run
// against a behavioural model of the EX stage.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, FlushE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int tests = 0;
  int fails = 0;

  execute_cycle #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        alusrc;
    logic [31:0] rd1, rd2, imm, resw, pce;
    logic [1:0]  fa, fb;
    logic        branch, flush, regw, memw;
    logic [31:0] exp_alu, exp_wd, exp_tgt;
    logic        exp_pcsrc, exp_regw, exp_memw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " RegWriteM"}, {31'b0, RegWriteM}, 32'h0);
    check({tag, " MemWriteM"}, {31'b0, MemWriteM}, 32'h0);
    check({tag, " ResultSrcM"}, {31'b0, ResultSrcM}, 32'h0);
    check({tag, " RD_M"}, {27'b0, RD_M}, 32'h0);
    check({tag, " PCPlus4M"}, PCPlus4M, 32'h0);
    check({tag, " WriteDataM"}, WriteDataM, 32'h0);
    check({tag, " ALU_ResultM"}, ALU_ResultM, 32'h0);
  endtask

  // Reference ALU taken straight from the operation table.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  vec_t vecs[16];

  function automatic vec_t mk(input logic [2:0] op, input logic alusrc, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] imm,
                              input logic [31:0] resw, input logic [31:0] pce,
                              input logic [1:0] fa, input logic [1:0] fb, input logic branch,
                              input logic flush, input logic regw, input logic memw,
                              input logic [31:0] ealu, input logic [31:0] ewd,
                              input logic [31:0] etgt, input logic epcsrc);
    vec_t v;
    v.op = op; v.alusrc = alusrc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
    v.pce = pce; v.fa = fa; v.fb = fb; v.branch = branch; v.flush = flush;
    v.regw = regw; v.memw = memw;
    v.exp_alu = ealu; v.exp_wd = ewd; v.exp_tgt = etgt; v.exp_pcsrc = epcsrc;
    v.exp_regw = regw & ~flush; v.exp_memw = memw & ~flush;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v, input int idx);
    ALUControlE = v.op; ALUSrcE = v.alusrc; RD1_E = v.rd1; RD2_E = v.rd2;
    Imm_Ext_E = v.imm; ResultW = v.resw; PCE = v.pce; ForwardA_E = v.fa; ForwardB_E = v.fb;
    BranchE = v.branch; FlushE = v.flush; RegWriteE = v.regw; MemWriteE = v.memw;
    RD_E = idx[4:0]; PCPlus4E = v.pce + 32'd4 + idx; ResultSrcE = idx[0];
  endtask

  logic [31:0] m_alu;
  logic        m_known;
  logic [31:0] sa, wd, sb, res, exp_pc4;
  logic        exp_pcsrc, r_rst;
  logic [4:0]  exp_rd;
  logic        exp_rs;

  initial begin
    // Sequential table: entry 8 forwards the 0x10 produced by entry 7.
    vecs[0]  = mk(3'd0, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd12, 5, 0, 0);
    vecs[1]  = mk(3'd1, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd2, 5, 0, 0);
    vecs[2]  = mk(3'd2, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd5, 5, 0, 0);
    vecs[3]  = mk(3'd3, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd7, 5, 0, 0);
    vecs[4]  = mk(3'd5, 0, 32'hFFFF_FFFF, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd1, 5, 0, 0);
    vecs[5]  = mk(3'd5, 0, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0,
                  32'hFFFF_FFFF, 0, 0);
    vecs[6]  = mk(3'd0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 1, 0);
    vecs[7]  = mk(3'd0, 0, 8, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 8, 0, 0);
    vecs[8]  = mk(3'd0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0, 32'h11, 1, 0, 0);
    vecs[9]  = mk(3'd0, 1, 4, 0, 8, 32'h33, 0, 0, 1, 0, 0, 0, 1, 32'd12, 32'h33, 8, 0);
    vecs[10] = mk(3'd1, 0, 9, 9, 32'hFFFF_FFF8, 0, 32'h100, 0, 0, 1, 0, 0, 0, 32'd0, 9,
                  32'hF8, 1);
    vecs[11] = mk(3'd1, 0, 9, 8, 32'hFFFF_FFF8, 0, 32'h100, 0, 0, 1, 0, 0, 0, 32'd1, 8,
                  32'hF8, 0);
    vecs[12] = mk(3'd1, 0, 9, 9, 32'hFFFF_FFF8, 0, 32'h100, 0, 0, 1, 1, 1, 1, 32'd0, 9,
                  32'hF8, 0);
    vecs[13] = mk(3'd4, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 5, 0, 0);
    vecs[14] = mk(3'd6, 0, 7, 5, 0, 32'h55, 0, 3, 3, 0, 0, 1, 0, 32'd0, 5, 0, 0);
    vecs[15] = mk(3'd7, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd0, 5, 0, 0);

    // Reset with nonzero inputs held for two edges.
    rst = 1'b0;
    drive_vec(vecs[0], 3);
    repeat (2) @(posedge clk);
    #1;
    check_regs_zero("reset");
    check("reset PCTargetE comb", PCTargetE, 32'h0);
    check("reset PCSrcE comb", {31'b0, PCSrcE}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first capture ALU", ALU_ResultM, 32'd12);
    check("first capture RD", {27'b0, RD_M}, 32'd3);

    // Directed table, one instruction per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_vec(vecs[i], i);
      #1;
      check($sformatf("v%0d PCSrcE", i), {31'b0, PCSrcE}, {31'b0, vecs[i].exp_pcsrc});
      check($sformatf("v%0d PCTargetE", i), PCTargetE, vecs[i].exp_tgt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d RegWriteM", i), {31'b0, RegWriteM}, {31'b0, vecs[i].exp_regw});
      check($sformatf("v%0d MemWriteM", i), {31'b0, MemWriteM}, {31'b0, vecs[i].exp_memw});
      check($sformatf("v%0d ResultSrcM", i), {31'b0, ResultSrcM}, i % 2);
      check($sformatf("v%0d RD_M", i), {27'b0, RD_M}, i);
      check($sformatf("v%0d PCPlus4M", i), PCPlus4M, vecs[i].pce + 32'd4 + i);
      if (!vecs[i].flush) begin
        check($sformatf("v%0d ALU_ResultM", i), ALU_ResultM, vecs[i].exp_alu);
        check($sformatf("v%0d WriteDataM", i), WriteDataM, vecs[i].exp_wd);
      end
    end

    // Mid-stream reset discards the instruction in EX.
    @(negedge clk);
    drive_vec(vecs[3], 7);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs_zero("midreset");
    @(negedge clk);
    rst = 1'b1;

    // Randomized run against the model; forwarding from MEM only while its value is defined.
    m_alu = 32'h0;
    m_known = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ALUControlE = 3'($urandom_range(0, 7));
      ALUSrcE = 1'($urandom);
      RD1_E = $urandom;
      RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      Imm_Ext_E = $urandom;
      ResultW = $urandom;
      PCE = $urandom;
      PCPlus4E = $urandom;
      RD_E = 5'($urandom);
      ForwardA_E = 2'($urandom);
      ForwardB_E = 2'($urandom);
      if (!m_known && ForwardA_E == 2'd2) ForwardA_E = 2'd0;
      if (!m_known && ForwardB_E == 2'd2) ForwardB_E = 2'd0;
      BranchE = 1'($urandom);
      FlushE = ($urandom_range(0, 7) == 0);
      RegWriteE = 1'($urandom);
      MemWriteE = 1'($urandom);
      ResultSrcE = 1'($urandom);
      r_rst = ($urandom_range(0, 29) != 0);
      rst = r_rst;

      sa = fwd_ref(ForwardA_E, RD1_E, ResultW, m_alu);
      wd = fwd_ref(ForwardB_E, RD2_E, ResultW, m_alu);
      sb = ALUSrcE ? Imm_Ext_E : wd;
      res = alu_ref(ALUControlE, sa, sb);
      exp_pcsrc = BranchE && (res == 32'h0) && !FlushE;
      exp_rd = RD_E;
      exp_pc4 = PCPlus4E;
      exp_rs = ResultSrcE;
      #1;
      check("rnd PCSrcE", {31'b0, PCSrcE}, {31'b0, exp_pcsrc});
      check("rnd PCTargetE", PCTargetE, PCE + Imm_Ext_E);
      @(posedge clk);
      #1;
      if (!r_rst) begin
        check_regs_zero("rnd reset");
        m_alu = 32'h0;
        m_known = 1'b1;
      end else begin
        check("rnd RegWriteM", {31'b0, RegWriteM}, {31'b0, RegWriteE && !FlushE});
        check("rnd MemWriteM", {31'b0, MemWriteM}, {31'b0, MemWriteE && !FlushE});
        check("rnd ResultSrcM", {31'b0, ResultSrcM}, {31'b0, exp_rs});
        check("rnd RD_M", {27'b0, RD_M}, {27'b0, exp_rd});
        check("rnd PCPlus4M", PCPlus4M, exp_pc4);
        if (!FlushE) begin
          check("rnd ALU_ResultM", ALU_ResultM, res);
          check("rnd WriteDataM", WriteDataM, wd);
        end
        m_alu = res;
        m_known = !FlushE;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
